// File: rtl/sdp_fifo_ctrl_if.sv
// Bus bundle for sdp_fifo_ctrl: producer push side, RAM port side and
// first-word-fall-through consumer side. The FIFO controller takes the slave
// modport; whatever surrounds it (producer, RAM, consumer) takes master.
interface sdp_fifo_ctrl_if #(
    parameter int unsigned ADDR  = 6,
    parameter int unsigned WIDTH = 16
);
    logic              push;
    logic [WIDTH-1:0]  push_data;
    logic              full;
    logic              ovf;
    logic              ram_wea;
    logic [ADDR-1:0]   ram_addra;
    logic [WIDTH-1:0]  ram_dia;
    logic [ADDR-1:0]   ram_addrb;
    logic [WIDTH-1:0]  ram_dob;
    logic              rd_valid;
    logic              rd_ready;
    logic [WIDTH-1:0]  rd_data;
    logic [ADDR+1:0]   count;

    modport slave (
        input  push, push_data, ram_dob, rd_ready,
        output full, ovf, ram_wea, ram_addra, ram_dia, ram_addrb,
               rd_valid, rd_data, count
    );

    modport master (
        output push, push_data, ram_dob, rd_ready,
        input  full, ovf, ram_wea, ram_addra, ram_dia, ram_addrb,
               rd_valid, rd_data, count
    );
endinterface

// File: rtl/sdp_fifo_ctrl.sv
// FIFO controller around an external simple-dual-port RAM with 1-cycle read
// latency. A 2-entry prefetch buffer (output register + skid register)
// gives first-word-fall-through reads at 1 word/cycle.
module sdp_fifo_ctrl #(
    parameter int unsigned ADDR  = 6,
    parameter int unsigned WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    sdp_fifo_ctrl_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR;

    logic [ADDR-1:0]  wptr_q, wptr_d;
    logic [ADDR-1:0]  rptr_q, rptr_d;
    logic [ADDR:0]    ram_cnt_q, ram_cnt_d;
    logic [ADDR+1:0]  count_q, count_d;
    logic             inflight_q;
    logic             ovf_q;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    logic             full;
    logic             wea;
    logic             pop;
    logic             rd_issue;
    logic [1:0]       occ;

    // Write/read-issue qualification and pointer/counter next state.
    // Occupancy after this cycle's pop never exceeds 2 (out + skid + inflight),
    // so a 2-bit sum is sufficient; pop implies out_valid, so no underflow.
    always_comb begin
        full      = (ram_cnt_q == (ADDR+1)'(DEPTH));
        wea       = bus.push & ~full & rst_n;
        pop       = out_valid_q & bus.rd_ready;
        occ       = {1'b0, out_valid_q} + {1'b0, skid_valid_q}
                  + {1'b0, inflight_q} - {1'b0, pop};
        rd_issue  = (ram_cnt_q != '0) && (occ < 2'd2);
        wptr_d    = wea      ? wptr_q + 1'b1 : wptr_q;
        rptr_d    = rd_issue ? rptr_q + 1'b1 : rptr_q;
        ram_cnt_d = ram_cnt_q + (ADDR+1)'(wea) - (ADDR+1)'(rd_issue);
        count_d   = count_q + (ADDR+2)'(wea) - (ADDR+2)'(pop);
    end

    // Prefetch buffer steering: landing RAM data fills the first slot that is
    // free after this cycle's pop; skid always drains into output first.
    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_data_d   = out_data_q;
        skid_data_d  = skid_data_q;
        if (pop) begin
            if (skid_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = skid_data_q;
                if (inflight_q) begin
                    skid_data_d = bus.ram_dob;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (inflight_q) begin
                out_valid_d = 1'b1;
                out_data_d  = bus.ram_dob;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (inflight_q) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = bus.ram_dob;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = bus.ram_dob;
            end
        end
    end

    // Control state: pointers, counters, valid flags, overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            ram_cnt_q    <= '0;
            count_q      <= '0;
            inflight_q   <= 1'b0;
            ovf_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            ram_cnt_q    <= ram_cnt_d;
            count_q      <= count_d;
            inflight_q   <= rd_issue;
            ovf_q        <= bus.push & full;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Data registers carry no reset; their valid flags qualify them.
    always_ff @(posedge clk) begin
        out_data_q  <= out_data_d;
        skid_data_q <= skid_data_d;
    end

    assign bus.full      = full;
    assign bus.ovf       = ovf_q;
    assign bus.ram_wea   = wea;
    assign bus.ram_addra = wptr_q;
    assign bus.ram_dia   = bus.push_data;
    assign bus.ram_addrb = rptr_q;
    assign bus.rd_valid  = out_valid_q;
    assign bus.rd_data   = out_data_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Self-checking bench for sdp_fifo_ctrl with a behavioural SDP RAM.
module tb_sdp_fifo_ctrl;
    localparam int unsigned ADDR  = 6;
    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sdp_fifo_ctrl_if #(.ADDR(ADDR), .WIDTH(WIDTH)) bus ();

    sdp_fifo_ctrl #(.ADDR(ADDR), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural RAM: write port A, registered read port B.
    logic [WIDTH-1:0] mem [2**ADDR];
    always @(posedge clk) begin
        if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dia;
        bus.ram_dob <= mem[bus.ram_addrb];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic             push;
        logic [WIDTH-1:0] data;
        logic             rr;
        logic             exp_wea;
        logic [ADDR-1:0]  exp_addra;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_data;
        logic [ADDR+1:0]  exp_count;
        logic             exp_full;
    } vec_t;

    vec_t vecs[16];
    logic [WIDTH-1:0] q[$];

    initial begin
        int accepted, ovf_cnt, sent, got, first_pop, last_pop, nextv;
        logic [WIDTH-1:0] expd;
        bit seen;

        //        push data      rr  wea addra valid exp_data   count full
        vecs[0]  = '{1'b1, 16'hA5A5, 1'b1, 1'b1, 6'd0, 1'b0, 16'h0000, 8'd0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd1, 1'b0, 16'h0000, 8'd1, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd1, 1'b0, 16'h0000, 8'd1, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd1, 1'b1, 16'hA5A5, 8'd1, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd1, 1'b0, 16'h0000, 8'd0, 1'b0};
        vecs[5]  = '{1'b1, 16'hB001, 1'b0, 1'b1, 6'd1, 1'b0, 16'h0000, 8'd0, 1'b0};
        vecs[6]  = '{1'b1, 16'hB002, 1'b0, 1'b1, 6'd2, 1'b0, 16'h0000, 8'd1, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 6'd3, 1'b0, 16'h0000, 8'd2, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 6'd3, 1'b1, 16'hB001, 8'd2, 1'b0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd3, 1'b1, 16'hB001, 8'd2, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd3, 1'b1, 16'hB002, 8'd1, 1'b0};
        vecs[11] = '{1'b1, 16'hC003, 1'b1, 1'b1, 6'd3, 1'b0, 16'h0000, 8'd0, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd4, 1'b0, 16'h0000, 8'd1, 1'b0};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd4, 1'b0, 16'h0000, 8'd1, 1'b0};
        vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd4, 1'b1, 16'hC003, 8'd1, 1'b0};
        vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd4, 1'b0, 16'h0000, 8'd0, 1'b0};

        // Reset held with push asserted.
        rst_n = 1'b0; bus.push = 1'b1; bus.push_data = 16'h1234; bus.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_full",  32'(bus.full),     32'd0);
        chk("rst_count", 32'(bus.count),    32'd0);
        chk("rst_wea",   32'(bus.ram_wea),  32'd0);
        chk("rst_ovf",   32'(bus.ovf),      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; bus.push = 1'b0;

        // Cycle-by-cycle vectors: latency, skid use, count tracking.
        for (int i = 0; i < 16; i++) begin
            bus.push = vecs[i].push; bus.push_data = vecs[i].data; bus.rd_ready = vecs[i].rr;
            @(negedge clk);
            chk($sformatf("vec%0d_wea", i),   32'(bus.ram_wea),   32'(vecs[i].exp_wea));
            chk($sformatf("vec%0d_addra", i), 32'(bus.ram_addra), 32'(vecs[i].exp_addra));
            chk($sformatf("vec%0d_valid", i), 32'(bus.rd_valid),  32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_count", i), 32'(bus.count),     32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_full", i),  32'(bus.full),      32'(vecs[i].exp_full));
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_data));
            @(posedge clk); #1;
        end

        // Fill with consumer stalled: 66 accepted, 4 overflows, pointer frozen.
        accepted = 0; ovf_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            bus.push = 1'b1; bus.push_data = 16'(i); bus.rd_ready = 1'b0;
            @(negedge clk);
            if (bus.ram_wea) accepted++;
            if (bus.ovf) ovf_cnt++;
            if (i >= 66) begin
                chk($sformatf("fill_rej_wea%0d", i),   32'(bus.ram_wea),   32'd0);
                chk($sformatf("fill_rej_addra%0d", i), 32'(bus.ram_addra), 32'd6);
            end
            @(posedge clk); #1;
        end
        bus.push = 1'b0;
        @(negedge clk);
        if (bus.ovf) ovf_cnt++;
        chk("fill_accepted", 32'(accepted),  32'd66);
        chk("fill_ovf",      32'(ovf_cnt),   32'd4);
        chk("fill_full",     32'(bus.full),  32'd1);
        chk("fill_count",    32'(bus.count), 32'd66);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fill_ovf_clear", 32'(bus.ovf), 32'd0);
        @(posedge clk); #1;

        // Drain: one pop per cycle, data 0..65 in order.
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 66; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d", i), {15'd0, bus.rd_valid, bus.rd_data}, {15'd0, 1'b1, 16'(i)});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_valid", 32'(bus.rd_valid), 32'd0);
        chk("drain_full",  32'(bus.full),     32'd0);
        chk("drain_count", 32'(bus.count),    32'd0);
        @(posedge clk); #1;

        // Streaming 300 words with continuous push and pop.
        sent = 0; got = 0; first_pop = -1; last_pop = -1; q.delete();
        for (int cyc = 0; cyc < 400 && got < 300; cyc++) begin
            bus.push = (sent < 300); bus.push_data = 16'h1000 + 16'(sent); bus.rd_ready = 1'b1;
            @(negedge clk);
            chk("stream_count", 32'(bus.count), 32'(q.size()));
            if (bus.rd_valid) begin
                expd = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                chk("stream_data", 32'(bus.rd_data), 32'(expd));
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                got++;
            end
            if (bus.ram_wea) begin q.push_back(bus.push_data); sent++; end
            @(posedge clk); #1;
        end
        bus.push = 1'b0;
        chk("stream_got",    32'(got), 32'd300);
        chk("stream_rate",   32'(last_pop - first_pop), 32'd299);
        chk("stream_first",  32'(first_pop), 32'd3);

        // Random push/ready with scoreboard, then reset mid-stream.
        nextv = 0; q.delete();
        for (int cyc = 0; cyc < 120; cyc++) begin
            bus.push = 1'($urandom_range(0, 1)); bus.push_data = 16'h2000 + 16'(nextv);
            bus.rd_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rand_count", 32'(bus.count), 32'(q.size()));
            if (bus.rd_valid && bus.rd_ready) begin
                expd = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                chk("rand_data", 32'(bus.rd_data), 32'(expd));
            end
            if (bus.ram_wea) begin q.push_back(bus.push_data); nextv++; end
            @(posedge clk); #1;
        end
        chk("rand_nonempty_before_reset", 32'(q.size() > 0 || bus.rd_valid), 32'd1);
        rst_n = 1'b0; bus.push = 1'b0; bus.rd_ready = 1'b0; q.delete();
        #2;
        chk("mid_rst_count", 32'(bus.count),    32'd0);
        chk("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.push = 1'b1; bus.push_data = 16'hBEEF; bus.rd_ready = 1'b1;
        @(posedge clk); #1;
        bus.push = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (bus.rd_valid) begin
                seen = 1'b1;
                chk("post_rst_data", 32'(bus.rd_data), 32'hBEEF);
            end
            @(posedge clk); #1;
        end
        chk("post_rst_seen", 32'(seen), 32'd1);
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            chk("post_rst_empty", {30'd0, bus.rd_valid, |bus.count}, 32'd0);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sdp_fifo_ctrl.md
Name: sdp_fifo_ctrl

Overview:
- Synchronous FIFO controller wrapped around an external simple-dual-port block RAM: one write port plus one read port with 1-cycle registered read latency.
- Both RAM clocks are tied to clk.
- Drives the RAM write and read ports and consumes its read data. Presents a first-word-fall-through valid/ready output through a 2-entry prefetch buffer, so back-to-back pops sustain 1 word/cycle.
- Total capacity is 2**ADDR + 2 words.

Parameters:
ADDR, 6, RAM address width; RAM depth DEPTH = 2**ADDR.
WIDTH, 16, data width.

Ports:
clk  input  1  single clock; also drives RAM clka/clkb.
rst_n  input  1  asynchronous active-low reset.
push  input  1  write request.
push_data  input  WIDTH  write data.
full  output  1  RAM store full; push ignored while high.
ovf  output  1  one-cycle pulse: push while full.
ram_wea  output  1  to RAM wea.
ram_addra  output  ADDR  to RAM addra.
ram_dia  output  WIDTH  to RAM dia.
ram_addrb  output  ADDR  to RAM addrb.
ram_dob  input  WIDTH  from RAM dob; valid the cycle after a read is issued.
rd_valid  output  1  rd_data valid.
rd_ready  input  1  consumer accepts; pop = rd_valid & rd_ready.
rd_data  output  WIDTH  head-of-FIFO data.
count  output  ADDR+2  total words held (RAM + in-flight + buffer).

Behaviour:
- Reset (async, rst_n=0): wptr=rptr=0, ram_cnt=0, inflight=0, out_valid=0, skid_valid=0, full=0, ovf=0, rd_valid=0, count=0. rd_data and skid data registers are not reset.
- Write path (combinational to RAM):
  - ram_wea = push & ~full; ram_addra = wptr; ram_dia = push_data.
  - On an accepted write, wptr increments and wraps DEPTH-1 -> 0.
- ram_cnt (ADDR+1 bits) counts words written to RAM and not yet issued for read.
  - full = (ram_cnt == DEPTH), registered or derived from the registered ram_cnt.
  - ovf = push & full, registered, so it pulses for one cycle.
- Read issue:
  - rd_issue = (ram_cnt != 0) & ((out_valid + skid_valid + inflight - pop) < 2).
  - ram_addrb = rptr, always driven. On rd_issue, rptr increments with wraparound.
  - inflight <= rd_issue.
  - ram_cnt <= ram_cnt + ram_wea - rd_issue; simultaneous write and issue leaves it unchanged.
- Same-cycle write and read of one address cannot occur: issue requires ram_cnt>0, so rptr never equals the address being written. No read-during-write mode is required of the RAM.
- Data landing (inflight=1): ram_dob is captured into the first free slot after this cycle's pop.
  - Output slot free (out_valid=0 or pop) and skid empty: data goes to the output register.
  - Otherwise data goes to the skid register.
  - On pop with skid_valid: skid moves to the output register; skid is refilled by landing data if any.
  - Ordering is strictly FIFO.
- rd_valid = out_valid. rd_data is stable while rd_valid & ~rd_ready.
- count <= count + ram_wea - pop.
- Latency: a push accepted at edge E0 into an empty FIFO gives rd_valid=1 after edge E2.
- Simultaneous push and pop in steady state: count is unchanged and throughput is 1/cycle.
- Reset asserted mid-operation: all state clears immediately and contents are discarded. The first push after rst_n deasserts is handled as for an empty FIFO.

Test Plan:
- Reset: hold rst_n=0 with push=1 -> rd_valid=0, full=0, count=0, ram_wea=0.
- Latency: single push of 0xA5A5 into empty FIFO with rd_ready=1 -> rd_valid high exactly 2 cycles after the write edge, rd_data=0xA5A5, count returns to 0.
- Fill with ADDR=6 and rd_ready=0: push 0..69 -> 66 words accepted (64 RAM + 2 buffer), full=1, count=66, pushes 66..69 produce an ovf pulse each with no pointer change.
- Drain: rd_ready=1 after fill -> 66 consecutive pops on 66 consecutive cycles, data 0..65 in order, then rd_valid=0, full=0.
- Streaming with wrap: continuous push and pop for 300 words -> 1 word/cycle after the initial 2-cycle latency, pointers wrap ≥4 times, data matches the scoreboard.
- Random rd_ready/push toggling plus an rst_n pulse mid-stream -> no loss, duplication or reorder before reset; after reset count=0 and the next push returns its own data only.
